// File: rtl/jtag_axi_dispatch.sv
// Request scheduler in the tck domain: queues JTAG requests into the request async FIFO
// and drains the response async FIFO into a held status word released by the JTAG reader.
module jtag_axi_dispatch #(
  parameter int INFO_W     = 72,
  parameter int STS_W      = 35,
  parameter int QDEPTH     = 4,
  parameter int SLOT_W     = 3,
  parameter int MAX_OUTSTD = 8
) (
  input  logic                             tck,
  input  logic                             trstn,
  input  logic                             req_new_i,
  input  logic [INFO_W-1:0]                req_info_i,
  input  logic                             clear_i,
  input  logic [SLOT_W-1:0]                afifo_slots_i,
  output logic                             afifo_wr_o,
  output logic [INFO_W-1:0]                afifo_wdata_o,
  input  logic                             rfifo_empty_i,
  output logic                             rfifo_rd_o,
  input  logic [STS_W-1:0]                 rfifo_rdata_i,
  output logic [STS_W-1:0]                 status_o,
  output logic                             status_valid_o,
  input  logic                             status_rd_i,
  output logic [$clog2(MAX_OUTSTD+1)-1:0]  outstanding_o,
  output logic                             busy_o,
  output logic                             ovf_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTD + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_HOLD} rsp_state_t;

  logic [INFO_W-1:0] q_mem [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  q_cnt, q_cnt_nxt;
  logic              q_empty, q_full;
  logic              slots_ok, outstd_ok, can_issue;
  logic              issue, bypass, push, pop, drop;
  logic [INFO_W-1:0] issue_data;
  logic [OUT_W-1:0]  outstd_nxt;
  logic              busy_nxt;

  rsp_state_t        state, state_nxt;
  logic              capture;

  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == CNT_W'(QDEPTH));
  // Compare instead of subtracting so a stale zero slot count with a pending write cannot wrap.
  assign slots_ok  = (afifo_slots_i > SLOT_W'(afifo_wr_o));
  assign outstd_ok = (outstanding_o < OUT_W'(MAX_OUTSTD));
  assign can_issue = !clear_i && slots_ok && outstd_ok;

  // An incoming request on an empty queue goes straight to the FIFO write register.
  assign bypass     = q_empty && req_new_i && can_issue;
  assign issue      = can_issue && (!q_empty || req_new_i);
  assign pop        = issue && !q_empty;
  assign push       = req_new_i && !clear_i && !q_full && !bypass;
  assign drop       = req_new_i && !clear_i && q_full;
  assign issue_data = q_empty ? req_info_i : q_mem[rd_ptr];

  always_comb begin
    q_cnt_nxt = q_cnt;
    if (clear_i) begin
      q_cnt_nxt = '0;
    end else if (push && !pop) begin
      q_cnt_nxt = q_cnt + CNT_W'(1);
    end else if (pop && !push) begin
      q_cnt_nxt = q_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    outstd_nxt = outstanding_o;
    if (issue && !capture) begin
      outstd_nxt = outstanding_o + OUT_W'(1);
    end else if (capture && !issue && (outstanding_o != '0)) begin
      outstd_nxt = outstanding_o - OUT_W'(1);
    end
  end

  assign busy_nxt = (q_cnt_nxt != '0) || (outstd_nxt != '0);

  always_ff @(posedge tck) begin
    if (push) begin
      q_mem[wr_ptr] <= req_info_i;
    end
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      q_cnt         <= '0;
      ovf_o         <= 1'b0;
      afifo_wr_o    <= 1'b0;
      afifo_wdata_o <= '0;
      outstanding_o <= '0;
      busy_o        <= 1'b0;
    end else begin
      afifo_wr_o <= issue;
      if (issue) begin
        afifo_wdata_o <= issue_data;
      end
      if (clear_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      q_cnt <= q_cnt_nxt;
      if (clear_i) begin
        ovf_o <= 1'b0;
      end else if (drop) begin
        ovf_o <= 1'b1;
      end
      outstanding_o <= outstd_nxt;
      busy_o        <= busy_nxt;
    end
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rfifo_rd_o = 1'b0;
    capture    = 1'b0;
    case (state)
      S_EMPTY: begin
        if (!rfifo_empty_i) begin
          rfifo_rd_o = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_FETCH: begin
        capture   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (status_rd_i) begin
          if (!rfifo_empty_i) begin
            rfifo_rd_o = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // A read strobe during reset would pop an entry the held state can never capture.
    if (!trstn) begin
      rfifo_rd_o = 1'b0;
    end
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      status_o       <= '0;
      status_valid_o <= 1'b0;
    end else begin
      if (capture) begin
        status_o <= rfifo_rdata_i;
      end
      status_valid_o <= (state_nxt == S_HOLD);
    end
  end

endmodule

// File: tb/tb_jtag_axi_dispatch.sv
// Scoreboard bench for jtag_axi_dispatch: request writes and captured status words are
// predicted when driven and matched in order as the design produces them.
module tb_jtag_axi_dispatch;

  localparam int INFO_W     = 72;
  localparam int STS_W      = 35;
  localparam int QDEPTH     = 4;
  localparam int SLOT_W     = 3;
  localparam int MAX_OUTSTD = 8;
  localparam int OUT_W      = $clog2(MAX_OUTSTD + 1);

  logic              tck = 1'b0;
  logic              trstn = 1'b0;
  logic              req_new_i = 1'b0;
  logic [INFO_W-1:0] req_info_i = '0;
  logic              clear_i = 1'b0;
  logic [SLOT_W-1:0] afifo_slots_i = '0;
  logic              afifo_wr_o;
  logic [INFO_W-1:0] afifo_wdata_o;
  logic              rfifo_empty_i = 1'b1;
  logic              rfifo_rd_o;
  logic [STS_W-1:0]  rfifo_rdata_i = '0;
  logic [STS_W-1:0]  status_o;
  logic              status_valid_o;
  logic              status_rd_i = 1'b0;
  logic [OUT_W-1:0]  outstanding_o;
  logic              busy_o;
  logic              ovf_o;

  jtag_axi_dispatch #(
    .INFO_W(INFO_W), .STS_W(STS_W), .QDEPTH(QDEPTH), .SLOT_W(SLOT_W), .MAX_OUTSTD(MAX_OUTSTD)
  ) dut (
    .tck(tck), .trstn(trstn), .req_new_i(req_new_i), .req_info_i(req_info_i),
    .clear_i(clear_i), .afifo_slots_i(afifo_slots_i), .afifo_wr_o(afifo_wr_o),
    .afifo_wdata_o(afifo_wdata_o), .rfifo_empty_i(rfifo_empty_i), .rfifo_rd_o(rfifo_rd_o),
    .rfifo_rdata_i(rfifo_rdata_i), .status_o(status_o), .status_valid_o(status_valid_o),
    .status_rd_i(status_rd_i), .outstanding_o(outstanding_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [INFO_W-1:0] exp_wr[$];
  logic [STS_W-1:0]  exp_sts[$];
  logic [STS_W-1:0]  resp_q[$];

  // One clock: model the response FIFO and match scoreboard entries after the edge.
  task automatic tick();
    logic rd_seen, was_valid;
    logic [INFO_W-1:0] ew;
    logic [STS_W-1:0] es;
    @(negedge tck);
    rd_seen   = rfifo_rd_o;
    was_valid = status_valid_o;
    @(posedge tck);
    #1;
    if (rd_seen) begin
      n_rd++;
      if (resp_q.size() != 0) rfifo_rdata_i = resp_q.pop_front();
    end
    rfifo_empty_i = (resp_q.size() == 0);
    if (afifo_wr_o) begin
      n_wr++;
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got data=%h, no write expected", afifo_wdata_o);
      end else begin
        ew = exp_wr.pop_front();
        if (afifo_wdata_o !== ew) begin
          failures++;
          $display("FAIL wr_data got=%h exp=%h", afifo_wdata_o, ew);
        end
      end
    end
    if (status_valid_o && !was_valid) begin
      checks++;
      if (exp_sts.size() == 0) begin
        failures++;
        $display("FAIL sts_unexpected got=%h, no status expected", status_o);
      end else begin
        es = exp_sts.pop_front();
        if (status_o !== es) begin
          failures++;
          $display("FAIL sts_data got=%h exp=%h", status_o, es);
        end
      end
    end
  endtask

  task automatic send_req(input logic [INFO_W-1:0] d, input bit expect_write);
    req_info_i = d;
    req_new_i  = 1'b1;
    if (expect_write) exp_wr.push_back(d);
    tick();
    req_new_i = 1'b0;
  endtask

  task automatic push_resp(input logic [STS_W-1:0] d);
    resp_q.push_back(d);
    exp_sts.push_back(d);
    rfifo_empty_i = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [63:0] r;
    int guard;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom()};
      push_resp(r[STS_W-1:0]);
    end
    guard = 0;
    while ((exp_sts.size() != 0 || status_valid_o) && guard < 100) begin
      status_rd_i = status_valid_o;
      tick();
      guard++;
    end
    status_rd_i = 1'b0;
    tick();
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("FAIL drain_timeout got=%0d cycles exp<100", guard);
    end
    checks++;
    if (outstanding_o !== '0) begin
      failures++;
      $display("FAIL drain_outstanding got=%0d exp=0", outstanding_o);
    end
  endtask

  task automatic test_reset();
    trstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({afifo_wr_o, rfifo_rd_o, status_valid_o, busy_o, ovf_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {afifo_wr_o, rfifo_rd_o, status_valid_o, busy_o, ovf_o});
    end
    checks++;
    if (afifo_wdata_o !== '0 || status_o !== '0) begin
      failures++;
      $display("FAIL reset_data got wdata=%h status=%h exp=0", afifo_wdata_o, status_o);
    end
    checks++;
    if (outstanding_o !== '0) begin
      failures++;
      $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o);
    end
    trstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    afifo_slots_i = 3'd4;
    base = n_wr;
    send_req(72'hA5, 1'b1);
    checks++;
    if (afifo_wr_o !== 1'b1 || outstanding_o !== OUT_W'(1)) begin
      failures++;
      $display("FAIL single_issue got wr=%b outstd=%0d exp wr=1 outstd=1", afifo_wr_o, outstanding_o);
    end
    tick();
    checks++;
    if (afifo_wr_o !== 1'b0 || n_wr - base !== 1) begin
      failures++;
      $display("FAIL single_pulse got wr=%b writes=%0d exp wr=0 writes=1", afifo_wr_o, n_wr - base);
    end
    push_resp(35'h1234);
    #1;
    checks++;
    if (rfifo_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL single_rd got=%b exp=1", rfifo_rd_o);
    end
    tick();
    checks++;
    if (status_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_fetch_valid got=%b exp=0", status_valid_o);
    end
    tick();
    checks++;
    if (status_valid_o !== 1'b1 || status_o !== 35'h1234 || outstanding_o !== '0) begin
      failures++;
      $display("FAIL single_status got v=%b s=%h o=%0d exp v=1 s=1234 o=0", status_valid_o, status_o, outstanding_o);
    end
    status_rd_i = 1'b1;
    tick();
    status_rd_i = 1'b0;
    checks++;
    if (status_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_release got=%b exp=0", status_valid_o);
    end
  endtask

  task automatic test_overflow();
    int base;
    afifo_slots_i = '0;
    base = n_wr;
    for (int i = 0; i < 5; i++) send_req(INFO_W'(32'h100 + i), i < QDEPTH);
    checks++;
    if (ovf_o !== 1'b1 || busy_o !== 1'b1 || n_wr != base) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b busy=%b writes=%0d exp 1 1 0", ovf_o, busy_o, n_wr - base);
    end
    afifo_slots_i = 3'd7;
    for (int k = 0; k < QDEPTH; k++) begin
      tick();
      checks++;
      if (afifo_wr_o !== 1'b1) begin
        failures++;
        $display("FAIL ovf_drain_%0d got=%b exp=1", k, afifo_wr_o);
      end
    end
    tick();
    checks++;
    if (afifo_wr_o !== 1'b0 || outstanding_o !== OUT_W'(4) || ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after got wr=%b o=%0d ovf=%b exp 0 4 1", afifo_wr_o, outstanding_o, ovf_o);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", ovf_o);
    end
    drain(4);
  endtask

  task automatic test_eff_slots();
    afifo_slots_i = 3'd1;
    send_req(INFO_W'(32'hE1), 1'b1);
    checks++;
    if (afifo_wr_o !== 1'b1) begin
      failures++;
      $display("FAIL eff_first got=%b exp=1", afifo_wr_o);
    end
    send_req(INFO_W'(32'hE2), 1'b1);
    checks++;
    if (afifo_wr_o !== 1'b0) begin
      failures++;
      $display("FAIL eff_blocked got=%b exp=0", afifo_wr_o);
    end
    tick();
    checks++;
    if (afifo_wr_o !== 1'b1) begin
      failures++;
      $display("FAIL eff_second got=%b exp=1", afifo_wr_o);
    end
    drain(2);
  endtask

  task automatic test_outstanding_limit();
    int base;
    bit got;
    afifo_slots_i = 3'd7;
    base = n_wr;
    for (int i = 0; i < MAX_OUTSTD + 1; i++) send_req(INFO_W'(32'h200 + i), 1'b1);
    repeat (3) tick();
    checks++;
    if (n_wr - base !== MAX_OUTSTD || outstanding_o !== OUT_W'(MAX_OUTSTD) || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL limit_hold got writes=%0d o=%0d busy=%b exp %0d %0d 1", n_wr - base, outstanding_o, busy_o, MAX_OUTSTD, MAX_OUTSTD);
    end
    push_resp(35'h0ABC);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      status_rd_i = status_valid_o;
      tick();
      got = afifo_wr_o;
    end
    status_rd_i = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL limit_release got no write exp one write");
    end
    drain(MAX_OUTSTD);
  endtask

  task automatic test_simultaneous();
    int base;
    afifo_slots_i = 3'd7;
    send_req(INFO_W'(32'h300), 1'b1);
    tick();
    push_resp(35'h0F0F);
    tick();
    send_req(INFO_W'(32'h301), 1'b1);
    checks++;
    if (outstanding_o !== OUT_W'(1) || afifo_wr_o !== 1'b1 || status_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_issue_capture got o=%0d wr=%b v=%b exp 1 1 1", outstanding_o, afifo_wr_o, status_valid_o);
    end
    drain(1);
    afifo_slots_i = '0;
    for (int i = 0; i < 5; i++) send_req(INFO_W'(32'h400 + i), 1'b0);
    checks++;
    if (ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_ovf_pre got=%b exp=1", ovf_o);
    end
    clear_i    = 1'b1;
    req_new_i  = 1'b1;
    req_info_i = INFO_W'(32'h4FF);
    tick();
    clear_i   = 1'b0;
    req_new_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_clear_req got ovf=%b busy=%b exp 0 0", ovf_o, busy_o);
    end
    afifo_slots_i = 3'd7;
    base = n_wr;
    repeat (3) tick();
    checks++;
    if (n_wr != base) begin
      failures++;
      $display("FAIL simul_clear_nowr got=%0d writes exp=0", n_wr - base);
    end
  endtask

  task automatic test_full_drop();
    int base;
    afifo_slots_i = '0;
    base = n_wr;
    for (int i = 0; i < QDEPTH; i++) send_req(INFO_W'(32'h500 + i), 1'b1);
    checks++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL full_no_ovf got=%b exp=0", ovf_o);
    end
    afifo_slots_i = 3'd7;
    send_req(INFO_W'(32'h5FF), 1'b0);
    checks++;
    if (ovf_o !== 1'b1 || afifo_wr_o !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_drop got ovf=%b wr=%b exp 1 1", ovf_o, afifo_wr_o);
    end
    repeat (4) tick();
    checks++;
    if (n_wr - base !== QDEPTH) begin
      failures++;
      $display("FAIL full_writes got=%0d exp=%0d", n_wr - base, QDEPTH);
    end
    drain(QDEPTH);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_response_hold();
    int rd_base;
    rd_base = n_rd;
    push_resp(35'h1_1111_1111);
    push_resp(35'h2_2222_2222);
    repeat (6) tick();
    checks++;
    if (n_rd - rd_base !== 1 || status_valid_o !== 1'b1 || status_o !== 35'h1_1111_1111) begin
      failures++;
      $display("FAIL hold_single_rd got rd=%0d v=%b s=%h exp 1 1 111111111", n_rd - rd_base, status_valid_o, status_o);
    end
    status_rd_i = 1'b1;
    #1;
    checks++;
    if (rfifo_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL hold_rd_same_cycle got=%b exp=1", rfifo_rd_o);
    end
    tick();
    status_rd_i = 1'b0;
    checks++;
    if (status_valid_o !== 1'b0 || status_o !== 35'h1_1111_1111) begin
      failures++;
      $display("FAIL hold_fetch got v=%b s=%h exp 0 111111111", status_valid_o, status_o);
    end
    tick();
    checks++;
    if (status_valid_o !== 1'b1 || status_o !== 35'h2_2222_2222 || outstanding_o !== '0) begin
      failures++;
      $display("FAIL hold_second got v=%b s=%h o=%0d exp 1 222222222 0", status_valid_o, status_o, outstanding_o);
    end
    status_rd_i = 1'b1;
    tick();
    status_rd_i = 1'b0;
    tick();
    checks++;
    if (n_rd - rd_base !== 2 || status_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_end got rd=%0d v=%b exp 2 0", n_rd - rd_base, status_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    push_resp(35'h0_5A5A);
    repeat (3) tick();
    checks++;
    if (status_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_hold got=%b exp=1", status_valid_o);
    end
    afifo_slots_i = '0;
    send_req(INFO_W'(32'h600), 1'b1);
    send_req(INFO_W'(32'h601), 1'b0);
    send_req(INFO_W'(32'h602), 1'b0);
    afifo_slots_i = 3'd7;
    tick();
    checks++;
    if (afifo_wr_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_inflight got=%b exp=1", afifo_wr_o);
    end
    trstn = 1'b0;
    tick();
    checks++;
    if ({afifo_wr_o, rfifo_rd_o, status_valid_o, busy_o, ovf_o} !== 5'b0 || outstanding_o !== '0) begin
      failures++;
      $display("FAIL mid_reset_flags got=%b o=%0d exp 00000 0", {afifo_wr_o, rfifo_rd_o, status_valid_o, busy_o, ovf_o}, outstanding_o);
    end
    checks++;
    if (afifo_wdata_o !== '0 || status_o !== '0) begin
      failures++;
      $display("FAIL mid_reset_data got wdata=%h status=%h exp 0", afifo_wdata_o, status_o);
    end
    exp_wr.delete();
    exp_sts.delete();
    resp_q.delete();
    rfifo_empty_i = 1'b1;
    trstn = 1'b1;
    base = n_wr;
    repeat (5) tick();
    checks++;
    if (n_wr != base || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_after got writes=%0d busy=%b exp 0 0", n_wr - base, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_eff_slots();
    test_outstanding_limit();
    test_simultaneous();
    test_full_drop();
    test_response_hold();
    test_reset_mid();
    checks++;
    if (exp_wr.size() != 0 || exp_sts.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got wr=%0d sts=%0d exp 0 0", exp_wr.size(), exp_sts.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
